// File: rtl/button_mode_sequencer.sv
// ---------------------------------------------------------------------------
// button_mode_sequencer
//
// Front-end controller for the 8-bit LED leg pattern engine. It conditions
// the raw active-low push button (2-FF synchroniser plus debounce), groups
// presses into a gesture by hold time and click count, and issues one
// registered pattern-mode command per gesture. It also produces the common
// step tick that advances the active pattern.
//
// Ports
//   pclk       in   1  system clock, all logic on the rising edge
//   rst_n      in   1  synchronous reset, active-low
//   button     in   1  raw asynchronous button, 0 = pressed
//   mode       out  3  0 ALL_ON, 1 SHL, 2 SHR, 3 CONVERGE, 4 DIVERGE
//   mode_load  out  1  single-cycle pulse, engine reloads its pattern seed
//   step_tick  out  1  single-cycle pulse every STEP_CYC cycles
//   busy       out  1  high while a gesture is being captured
// ---------------------------------------------------------------------------
module button_mode_sequencer #(
    parameter int CNT_W        = 32,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SHORT_CYC    = 100000000,
    parameter int LONG_CYC     = 250000000,
    parameter int GAP_CYC      = 25000000,
    parameter int STEP_CYC     = 33554432
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       button,
    output logic [2:0] mode,
    output logic       mode_load,
    output logic       step_tick,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_T   = CNT_W'(SHORT_CYC);
    localparam logic [CNT_W-1:0] LONG_T    = CNT_W'(LONG_CYC);

    localparam logic [2:0] MODE_ALL_ON   = 3'd0;
    localparam logic [2:0] MODE_SHL      = 3'd1;
    localparam logic [2:0] MODE_SHR      = 3'd2;
    localparam logic [2:0] MODE_CONVERGE = 3'd3;
    localparam logic [2:0] MODE_DIVERGE  = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        GAP    = 2'd2,
        DECIDE = 2'd3
    } state_t;

    logic [1:0]       sync_q;
    logic             btn_db;
    logic [CNT_W-1:0] db_cnt;

    state_t           state, state_next;
    logic [CNT_W-1:0] hold_cnt, hold_next;
    logic [CNT_W-1:0] gap_cnt, gap_next;
    logic [1:0]       click_cnt, click_next;
    logic [CNT_W-1:0] first_hold, first_next;
    logic [2:0]       mode_q, mode_next, decoded;
    logic             load_q, load_next;
    logic [CNT_W-1:0] step_cnt;

    // Synchroniser and debouncer. Both rest at 1 (released). The debounced
    // level only follows btn_s after it has disagreed for DEBOUNCE_CYC
    // consecutive cycles; any agreement restarts the count.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else begin
            sync_q <= {sync_q[0], button};
            if (sync_q[1] != btn_db) begin
                if (db_cnt == DEB_LAST) begin
                    btn_db <= sync_q[1];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Gesture FSM state and datapath registers.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            click_cnt  <= 2'd0;
            first_hold <= '0;
            mode_q     <= MODE_CONVERGE;
            load_q     <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            gap_cnt    <= gap_next;
            click_cnt  <= click_next;
            first_hold <= first_next;
            mode_q     <= mode_next;
            load_q     <= load_next;
        end
    end

    // Only the first click's hold time selects among the shift modes;
    // extra clicks pick converge/diverge regardless of their hold.
    always_comb begin
        decoded = MODE_ALL_ON;
        case (click_cnt)
            2'd2:    decoded = MODE_CONVERGE;
            2'd3:    decoded = MODE_DIVERGE;
            default: begin
                if (first_hold >= LONG_T)
                    decoded = MODE_SHR;
                else if (first_hold >= SHORT_T)
                    decoded = MODE_SHL;
                else
                    decoded = MODE_ALL_ON;
            end
        endcase
    end

    // Next-state logic. In GAP the timeout is tested first so a press that
    // lands on the last gap cycle is ignored. mode and mode_load are
    // registered on the GAP->DECIDE edge so both appear in the DECIDE cycle.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        gap_next   = gap_cnt;
        click_next = click_cnt;
        first_next = first_hold;
        mode_next  = mode_q;
        load_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!btn_db) begin
                    state_next = PRESS;
                    hold_next  = '0;
                    click_next = 2'd1;
                end
            end
            PRESS: begin
                if (btn_db) begin
                    if (click_cnt == 2'd1)
                        first_next = hold_cnt;
                    gap_next   = '0;
                    state_next = GAP;
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = DECIDE;
                    load_next  = 1'b1;
                    mode_next  = decoded;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                    if (!btn_db) begin
                        state_next = PRESS;
                        hold_next  = '0;
                        if (click_cnt != 2'd3)
                            click_next = click_cnt + 2'd1;
                    end
                end
            end
            DECIDE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Step counter restarts on a mode load so the new pattern gets a full
    // period before its first step.
    always_ff @(posedge pclk) begin
        if (!rst_n)
            step_cnt <= '0;
        else if (load_q || step_cnt == STEP_LAST)
            step_cnt <= '0;
        else
            step_cnt <= step_cnt + 1'b1;
    end

    assign step_tick = (step_cnt == STEP_LAST) && !load_q;
    assign mode      = mode_q;
    assign mode_load = load_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_button_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_button_mode_sequencer
//
// Self-checking bench for button_mode_sequencer with small parameters.
// A timestamp-based reference model predicts mode, mode_load, busy and
// step_tick every cycle; directed gestures add literal expectations.
// ---------------------------------------------------------------------------
module tb_button_mode_sequencer;

    localparam int CNT_W = 8;
    localparam int DEB   = 4;
    localparam int SHORT = 20;
    localparam int LONG  = 50;
    localparam int GAP   = 16;
    localparam int STEP  = 8;
    localparam int HMAX  = (1 << CNT_W) - 1;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       button;
    logic [2:0] mode;
    logic       mode_load;
    logic       step_tick;
    logic       busy;

    button_mode_sequencer #(
        .CNT_W(CNT_W), .DEBOUNCE_CYC(DEB), .SHORT_CYC(SHORT),
        .LONG_CYC(LONG), .GAP_CYC(GAP), .STEP_CYC(STEP)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .button(button),
        .mode(mode), .mode_load(mode_load), .step_tick(step_tick), .busy(busy)
    );

    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at cycle", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        button = level;
        repeat (cycles) @(negedge pclk);
    endtask

    function automatic int decodeGesture(input int clicks, input int fh);
        if (clicks >= 3) return 4;
        if (clicks == 2) return 3;
        if (fh < SHORT)  return 0;
        if (fh < LONG)   return 1;
        return 2;
    endfunction

    // Reference model: debounce as a run length, gestures as timestamps.
    int  cyc = 0;
    bit  syn0, syn1, db, dbp;
    int  run;
    bit  active, pressing, deciding, load_prev;
    int  press_start, rel_cyc, clicks, first_hold;
    int  m_mode;
    bit  m_load, m_tick, m_valid = 0;
    int  anchor;

    always @(posedge pclk) begin
        cyc++;
        if (rst_n === 1'b0) begin
            syn0 = 1; syn1 = 1; db = 1; run = 0;
            active = 0; pressing = 0; deciding = 0; clicks = 0;
            m_mode = 3; m_load = 0; anchor = cyc; m_valid = 1;
        end else if (m_valid) begin
            dbp = db;
            if (syn1 != db) begin
                run++;
                if (run == DEB) begin
                    db  = syn1;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            syn1 = syn0;
            syn0 = button;

            load_prev = m_load;
            m_load    = 0;
            if (deciding) begin
                deciding = 0;
                active   = 0;
            end else if (!active) begin
                if (!dbp) begin
                    active = 1; pressing = 1; press_start = cyc; clicks = 1;
                end
            end else if (pressing) begin
                if (dbp) begin
                    pressing = 0;
                    rel_cyc  = cyc;
                    if (clicks == 1) begin
                        first_hold = cyc - press_start - 1;
                        if (first_hold > HMAX) first_hold = HMAX;
                    end
                end
            end else begin
                if (cyc - rel_cyc == GAP) begin
                    m_load   = 1;
                    m_mode   = decodeGesture(clicks, first_hold);
                    deciding = 1;
                end else if (!dbp) begin
                    pressing = 1; press_start = cyc;
                    if (clicks < 3) clicks++;
                end
            end
            if (load_prev) anchor = cyc;
        end
        m_tick = (((cyc - anchor) % STEP) == STEP - 1) && !m_load;
    end

    // Per-cycle comparison plus bookkeeping for the directed checks.
    int dut_loads = 0;
    int dut_ticks = 0;
    int last_load_cyc = 0;
    int load_to_tick = -1;
    bit want_tick = 0;

    always @(negedge pclk) begin
        if (m_valid) begin
            checkOutput("mode", mode, m_mode);
            checkOutput("mode_load", mode_load, m_load);
            checkOutput("busy", busy, active);
            checkOutput("step_tick", step_tick, m_tick);
            if (mode_load === 1'b1) begin
                dut_loads++;
                last_load_cyc = cyc;
                want_tick = 1;
            end else if (step_tick === 1'b1 && want_tick) begin
                load_to_tick = cyc - last_load_cyc;
                want_tick = 0;
            end
            if (step_tick === 1'b1) dut_ticks++;
        end
    end

    int rel_raw;

    task automatic gesture(input int nclicks, input int hold, input int gap);
        for (int i = 0; i < nclicks; i++) begin
            applyStimulus(1'b0, hold);
            rel_raw = cyc;
            applyStimulus(1'b1, (i == nclicks - 1) ? 40 : gap);
        end
    endtask

    task automatic directed(input string name, input int nclicks, input int hold,
                            input int exp_mode, input bit chk_lat);
        int l0;
        l0 = dut_loads;
        gesture(nclicks, hold, 8);
        checkOutput({name, "_loads"}, dut_loads - l0, 1);
        checkOutput({name, "_mode"}, mode, exp_mode);
        if (chk_lat) checkOutput({name, "_latency"}, last_load_cyc - rel_raw, 23);
    endtask

    initial begin
        int t0, l0;
        rst_n  = 1'b0;
        button = 1'b0;
        repeat (4) @(negedge pclk);
        checkOutput("reset_mode", mode, 3);
        checkOutput("reset_load", mode_load, 0);
        checkOutput("reset_busy", busy, 0);
        button = 1'b1;
        @(negedge pclk);
        rst_n = 1'b1;
        t0 = dut_ticks;
        l0 = dut_loads;
        applyStimulus(1'b1, 40);
        checkOutput("idle_ticks", dut_ticks - t0, 5);
        checkOutput("idle_loads", dut_loads - l0, 0);

        directed("short", 1, 10, 0, 1);
        directed("mid",   1, 30, 1, 1);
        directed("long",  1, 80, 2, 1);
        directed("dbl",   2, 10, 3, 0);
        directed("tri",   3, 10, 4, 0);
        directed("quad",  4, 10, 4, 0);

        l0 = dut_loads;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2);
            applyStimulus(1'b1, 10);
        end
        applyStimulus(1'b1, 30);
        checkOutput("glitch_loads", dut_loads - l0, 0);

        l0 = dut_loads;
        applyStimulus(1'b0, 2); applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2); applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 2); applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 15);
        applyStimulus(1'b1, 40);
        checkOutput("bounce_loads", dut_loads - l0, 1);
        checkOutput("bounce_mode", mode, 0);

        l0 = dut_loads;
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 12);
        rst_n = 1'b0;
        applyStimulus(1'b1, 3);
        rst_n = 1'b1;
        applyStimulus(1'b1, 40);
        checkOutput("gapreset_loads", dut_loads - l0, 0);
        checkOutput("gapreset_mode", mode, 3);

        load_to_tick = -1;
        directed("sat", 1, 300, 2, 1);
        checkOutput("load_to_tick", load_to_tick, 8);

        for (int g = 0; g < 30; g++) begin
            int nc;
            nc = $urandom_range(1, 4);
            for (int c = 0; c < nc; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(1'b0, $urandom_range(1, 3));
                    applyStimulus(1'b1, $urandom_range(1, 2));
                end
                applyStimulus(1'b0, $urandom_range(2, 70));
                applyStimulus(1'b1, (c == nc - 1) ? $urandom_range(14, 45) : $urandom_range(3, 22));
            end
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                applyStimulus(1'b1, 2);
                rst_n = 1'b1;
            end
        end

        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 2) != 0), 1);
        applyStimulus(1'b1, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
